vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Sequencer that sits behind the water vending FSM and turns each vend decision into the physical actions. A decision is a bottle-out flag plus a change code. The block runs the dispense motor, confirms the bottle drop within a timeout, then pulses the Rs 5 coin hopper once per coin owed. It accepts one decision at a time over a valid/ready handshake and latches a fault on a missing drop.

## Interface
Parameters:
- MOTOR_CYCLES, 8 — cycles motor_en is held high per bottle (≥1)
- DROP_TIMEOUT, 16 — max cycles to wait for drop_sense after motor stops (≥1)
- PULSE_CYCLES, 2 — coin_pulse high time per coin (≥1)
- GAP_CYCLES, 2 — coin_pulse low time after each coin (≥1)
- CNT_W, 5 — timer width; must hold max(MOTOR_CYCLES, DROP_TIMEOUT, PULSE_CYCLES, GAP_CYCLES)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  vend decision present
- req_ready  out  1  block can accept a decision
- req_out  in  1  1 = dispense one bottle
- req_change  in  2  coins owed in Rs 5 units: 00 none, 01 Rs 5, 10 Rs 10, 11 Rs 15
- drop_sense  in  1  bottle-drop sensor, level
- fault_clr  in  1  clears FAULT
- motor_en  out  1  dispense motor drive
- coin_pulse  out  1  hopper drive, one pulse per coin
- busy  out  1  high in any state except IDLE and FAULT
- fault  out  1  high in FAULT
- vend_done  out  1  one-cycle pulse when a request completes normally

## Operation
- Control is a registered FSM with states IDLE, MOTOR, WAIT_DROP, PAY_HI, PAY_LO, DONE, FAULT.
- Reset (rst=0 at posedge): state=IDLE, all timers and coin count cleared. Outputs are motor_en=0, coin_pulse=0, busy=0, fault=0, vend_done=0, req_ready=1.
- req_ready=1 only in IDLE. A transfer occurs when req_valid && req_ready at a posedge. At that edge req_out and req_change are latched, with the coin count set to req_change.
- IDLE → MOTOR if req_out=1. Otherwise IDLE → PAY_HI if coins>0, else → DONE.
- MOTOR: motor_en=1 for exactly MOTOR_CYCLES cycles, then → WAIT_DROP. drop_sense is ignored in MOTOR.
- WAIT_DROP: motor_en=0, and drop_sense is sampled each cycle.
  - drop_sense=1 → PAY_HI if coins>0, else → DONE.
  - No drop after DROP_TIMEOUT cycles → FAULT. Owed coins are discarded.
  - If drop_sense=1 on the final timeout cycle, the drop wins.
- PAY_HI: coin_pulse=1 for PULSE_CYCLES cycles, then → PAY_LO with coins decremented.
- PAY_LO: coin_pulse=0 for GAP_CYCLES cycles, then → PAY_HI if coins>0, else → DONE.
- DONE: vend_done=1 for one cycle, then → IDLE.
- FAULT: all drives low, req_ready=0. fault_clr=1 → IDLE. fault_clr outside FAULT has no effect.
- Reset mid-operation aborts immediately: any in-flight motor or coin pulse is cut at that edge, and no vend_done is issued.

## Timing
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs, including req_ready.
- Accept at edge N: motor_en is high during cycles N+1 … N+MOTOR_CYCLES.
- First drop_sense sample is at cycle N+MOTOR_CYCLES+1.
- Drop seen at cycle D: first coin_pulse high at D+1. Each coin takes PULSE_CYCLES+GAP_CYCLES cycles.
- vend_done is asserted in the cycle after the last PAY_LO cycle, or at D+1 when no coins are owed.
- Null request (out=0, change=00) accepted at N: vend_done at N+1, req_ready high again at N+2.
- Throughput: at most one request in flight; req_ready low from N+1 until the cycle after DONE.

## Structure
- Shared package vend_pkg holds:
  - state encoding enum vend_disp_state_t
  - change code constants CHG_NONE/CHG_5/CHG_10/CHG_15 (2'b00…2'b11), shared with the vending FSM
  - default timing constants
- One sub-module, vend_timer: loadable down-counter with load value, enable and zero flag, CNT_W wide. It is shared by the MOTOR, WAIT_DROP, PAY_HI and PAY_LO timing.
- The coin count is a 2-bit register local to the controller.

## Test plan
- Reset: hold rst=0 for 2 cycles with req_valid=1 → all outputs 0 except req_ready=1, and no transfer.
- Bottle, Rs 10 change (out=1, change=10), drop_sense high 3 cycles after motor stops:
  - motor_en high 8 cycles
  - two coin_pulse pulses of 2 high / 2 low
  - vend_done one cycle after the last gap
- Bottle, no change (out=1, change=00), drop_sense never high: after 8 motor + 16 wait cycles → fault=1 and req_ready=0. Then fault_clr=1 → IDLE and req_ready=1, with no vend_done.
- Change only (out=0, change=01) → one coin_pulse starting the cycle after accept, then vend_done.
- Drop on the final timeout cycle → no fault and vend_done asserted. Separately, a drop pulse during MOTOR only → ignored and FAULT reached.
- rst=0 mid-PAY_HI with change=11 → coin_pulse low the next cycle, IDLE, no further pulses. A back-to-back request presented during busy is held until req_ready=1.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: state encoding, change codes and default timing for the dispense sequencer
package vend_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOTOR,
        ST_WAIT_DROP,
        ST_PAY_HI,
        ST_PAY_LO,
        ST_DONE,
        ST_FAULT
    } vend_disp_state_t;
    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_15   = 2'b11;
    localparam int DEF_MOTOR_CYCLES = 8;
    localparam int DEF_DROP_TIMEOUT = 16;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_CNT_W        = 5;
endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// vend_dispense_ctrl_if: valid/ready vend decision channel from the vending FSM
interface vend_dispense_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_out;
    logic [1:0] req_change;
    modport master (output req_valid, req_out, req_change, input req_ready);
    modport slave  (input req_valid, req_out, req_change, output req_ready);
endinterface

// File: rtl/vend_timer.sv
// vend_timer: loadable down-counter that saturates at zero and flags it
module vend_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && !zero)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: runs the motor, confirms the drop, then pays change coin by coin
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = DEF_MOTOR_CYCLES,
    parameter int DROP_TIMEOUT = DEF_DROP_TIMEOUT,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    vend_dispense_ctrl_if.slave   req,
    input  logic                  drop_sense,
    input  logic                  fault_clr,
    output logic                  motor_en,
    output logic                  coin_pulse,
    output logic                  busy,
    output logic                  fault,
    output logic                  vend_done
);
    localparam logic [CNT_W-1:0] LD_MOTOR = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(DROP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_HI    = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LO    = CNT_W'(GAP_CYCLES - 1);

    vend_disp_state_t state, nxt;
    logic [1:0]       coins;
    logic             ld, zero;
    logic [CNT_W-1:0] ld_val;

    assign req.req_ready = state == ST_IDLE;
    assign motor_en      = state == ST_MOTOR;
    assign coin_pulse    = state == ST_PAY_HI;
    assign vend_done     = state == ST_DONE;
    assign fault         = state == ST_FAULT;
    assign busy          = !(state == ST_IDLE || state == ST_FAULT);

    vend_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .en       (busy && state != ST_DONE),
        .load_val (ld_val),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            coins <= CHG_NONE;
        end else begin
            state <= nxt;
            if (req.req_valid && req.req_ready)
                coins <= req.req_change;
            else if (state == ST_PAY_HI && zero)
                coins <= coins - 1'b1;
            else if (state == ST_WAIT_DROP && !drop_sense && zero)
                coins <= CHG_NONE;
        end
    end

    // Each timed state preloads the timer with its length minus one on entry
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = '0;
        unique case (state)
            ST_IDLE: if (req.req_valid) begin
                if (req.req_out) begin
                    nxt = ST_MOTOR; ld = 1'b1; ld_val = LD_MOTOR;
                end else if (req.req_change != CHG_NONE) begin
                    nxt = ST_PAY_HI; ld = 1'b1; ld_val = LD_HI;
                end else
                    nxt = ST_DONE;
            end
            ST_MOTOR: if (zero) begin
                nxt = ST_WAIT_DROP; ld = 1'b1; ld_val = LD_WAIT;
            end
            ST_WAIT_DROP: if (drop_sense) begin
                if (coins != CHG_NONE) begin
                    nxt = ST_PAY_HI; ld = 1'b1; ld_val = LD_HI;
                end else
                    nxt = ST_DONE;
            end else if (zero)
                nxt = ST_FAULT;
            ST_PAY_HI: if (zero) begin
                nxt = ST_PAY_LO; ld = 1'b1; ld_val = LD_LO;
            end
            ST_PAY_LO: if (zero) begin
                if (coins != CHG_NONE) begin
                    nxt = ST_PAY_HI; ld = 1'b1; ld_val = LD_HI;
                end else
                    nxt = ST_DONE;
            end
            ST_DONE:  nxt = ST_IDLE;
            ST_FAULT: if (fault_clr) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: table, random and corner-case checks against a timeline model
module tb_vend_dispense_ctrl;
    localparam int M = 8, T = 16, P = 2, G = 2;

    typedef struct {
        bit         o;
        logic [1:0] c;
        int         d;
        int         nk;
        int         e_done;
        int         e_coins;
        bit         e_fault;
    } vec_t;

    logic clk = 0, rst = 0, drop_sense = 0, fault_clr = 0;
    logic motor_en, coin_pulse, busy, fault, vend_done;
    int   total = 0, bad = 0;
    vec_t tbl[8];
    logic [5:0] eb[8] = '{6'b010100, 6'b010100, 6'b010000, 6'b010000,
                          6'b010010, 6'b100000, 6'b010010, 6'b100000};

    vend_dispense_ctrl_if bus();

    vend_dispense_ctrl #(
        .MOTOR_CYCLES(M), .DROP_TIMEOUT(T), .PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus),
        .drop_sense (drop_sense),
        .fault_clr  (fault_clr),
        .motor_en   (motor_en),
        .coin_pulse (coin_pulse),
        .busy       (busy),
        .fault      (fault),
        .vend_done  (vend_done)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {bus.req_ready, busy, motor_en, coin_pulse, vend_done, fault};
    endfunction

    // Expected {ready,busy,motor,coin,done,fault} k cycles after the accept edge
    function automatic logic [5:0] model(bit o, int c, int d, int k);
        int s, dn;
        logic [5:0] r;
        if (o && d == 0)
            return k <= M ? 6'b011000 : k <= M + T ? 6'b010000 : 6'b000001;
        s  = o ? M + d + 1 : 1;
        dn = s + c * (P + G);
        if (k > dn) return 6'b100000;
        r    = 6'b010000;
        r[3] = o && k <= M;
        r[2] = k >= s && k < dn && ((k - s) % (P + G)) < P;
        r[1] = k == dn;
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%b want=%b", name, k, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_i("ready_wait", int'(bus.req_ready), 1);
    endtask

    task automatic run(input bit o, input logic [1:0] c, input int d, input int nk,
                       output int done_k, output int ncoin, output bit flt);
        int  len;
        bit  pc = 0;
        logic [5:0] v;
        done_k = 0; ncoin = 0; flt = 0;
        wait_ready();
        bus.req_valid = 1; bus.req_out = o; bus.req_change = c;
        @(posedge clk);
        len = (o && d == 0) ? M + T + 3 : (o ? M + d + 1 : 1) + int'(c) * (P + G) + 1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            bus.req_valid = 0;
            v = outs();
            chk("cycle", k, v, model(o, int'(c), d, k));
            drop_sense = (o && d != 0 && k == M + d) || (k == nk);
            if (v[1] && done_k == 0) done_k = k;
            if (v[2] && !pc) ncoin++;
            pc  = v[2];
            flt = flt | v[0];
        end
        drop_sense = 0;
        if (o && d == 0) begin
            fault_clr = 1;
            @(negedge clk);
            fault_clr = 0;
            chk("fault_clr", 0, outs(), 6'b100000);
        end
    endtask

    initial begin
        int  dk, nc, hits;
        bit  fl;
        bit  o;
        logic [1:0] c;
        int  d, nk;
        tbl[0] = '{1'b1, 2'd2, 3,  0, 20, 2, 1'b0};
        tbl[1] = '{1'b1, 2'd0, 0,  0, 0,  0, 1'b1};
        tbl[2] = '{1'b0, 2'd1, 0,  0, 5,  1, 1'b0};
        tbl[3] = '{1'b1, 2'd0, 16, 0, 25, 0, 1'b0};
        tbl[4] = '{1'b1, 2'd0, 0,  4, 0,  0, 1'b1};
        tbl[5] = '{1'b0, 2'd0, 0,  0, 1,  0, 1'b0};
        tbl[6] = '{1'b1, 2'd3, 1,  0, 22, 3, 1'b0};
        tbl[7] = '{1'b0, 2'd3, 0,  0, 13, 3, 1'b0};

        bus.req_valid = 1; bus.req_out = 1; bus.req_change = 2'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset", i, outs(), 6'b100000);
        end
        bus.req_valid = 0;
        rst = 1;
        @(negedge clk);
        chk("post_reset", 0, outs(), 6'b100000);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].o, tbl[i].c, tbl[i].d, tbl[i].nk, dk, nc, fl);
            chk_i($sformatf("tbl%0d_done", i), dk, tbl[i].e_done);
            chk_i($sformatf("tbl%0d_coins", i), nc, tbl[i].e_coins);
            chk_i($sformatf("tbl%0d_fault", i), int'(fl), int'(tbl[i].e_fault));
        end

        for (int i = 0; i < 40; i++) begin
            o  = 1'($urandom_range(0, 1));
            c  = 2'($urandom_range(0, 3));
            d  = o ? $urandom_range(0, T) : 0;
            nk = o ? $urandom_range(0, M) : 0;
            run(o, c, d, nk, dk, nc, fl);
        end

        wait_ready();
        bus.req_valid = 1; bus.req_out = 0; bus.req_change = 2'd3;
        @(posedge clk);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            bus.req_valid = 0;
            chk("pay_hi", k, outs(), 6'b010100);
        end
        rst = 0;
        @(negedge clk);
        chk("rst_cut", 0, outs(), 6'b100000);
        rst = 1;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (coin_pulse || vend_done || busy) hits++;
        end
        chk_i("after_rst_quiet", hits, 0);

        bus.req_valid = 1; bus.req_out = 0; bus.req_change = 2'd1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_change = 2'd0;
            chk("b2b", k, outs(), eb[k-1]);
            if (k == 7) bus.req_valid = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
